// File: rtl/keystream_scheduler_pkg.sv
// Shared types and constants for the keystream scheduler.
// Optional build macro KEYSTREAM_XOR_MIX_EN is consumed by keystream_scheduler.
package keystream_scheduler_pkg;

  localparam int unsigned DEFAULT_EXTRACT_LAT = 6;
  localparam int unsigned NUM_TRIP            = 3;
  localparam int unsigned VAL_W               = 32;
  localparam int unsigned RES_W               = 23;
  localparam int unsigned WAIT_W              = 8;
  localparam int unsigned IDX_W               = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAPT = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  typedef logic [7:0] key_byte_t;

endpackage

// File: rtl/keystream_scheduler.sv
// Sequences chaos triplets through an external extractor and emits three key bytes per triplet.
// Build macro KEYSTREAM_XOR_MIX_EN folds the upper result bits into each key byte.
module keystream_scheduler
  import keystream_scheduler_pkg::*;
#(
  parameter int unsigned EXTRACT_LAT = DEFAULT_EXTRACT_LAT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_val  [NUM_TRIP],
  output logic             ext_en,
  output logic [VAL_W-1:0] ext_val [NUM_TRIP],
  input  logic [RES_W-1:0] ext_res [NUM_TRIP],
  output logic             key_valid,
  input  logic             key_ready,
  output key_byte_t        key_byte,
  output logic             busy,
  output logic [CNT_W-1:0] trip_cnt
);

  state_e            r_state,  w_state_nxt;
  logic [VAL_W-1:0]  r_op      [NUM_TRIP];
  logic [VAL_W-1:0]  w_op_nxt  [NUM_TRIP];
  logic [RES_W-1:0]  r_res     [NUM_TRIP];
  logic [RES_W-1:0]  w_res_nxt [NUM_TRIP];
  logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
  logic [WAIT_W-1:0] r_wait,   w_wait_nxt;
  logic [CNT_W-1:0]  r_trip,   w_trip_nxt;
  logic              r_in_ready, r_ext_en, r_key_valid, r_busy;
  key_byte_t         r_key_byte, w_key_nxt;
  logic [RES_W-1:0]  w_sel;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait;
    w_trip_nxt  = r_trip;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          for (int i = 0; i < NUM_TRIP; i++) w_op_nxt[i] = in_val[i];
          w_wait_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_wait_nxt = r_wait + WAIT_W'(1);
        if (r_wait == WAIT_W'(EXTRACT_LAT - 1)) w_state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        for (int i = 0; i < NUM_TRIP; i++) w_res_nxt[i] = ext_res[i];
        w_idx_nxt   = '0;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (r_key_valid && key_ready) begin
          if (r_idx == IDX_W'(NUM_TRIP - 1)) begin
            w_trip_nxt  = r_trip + CNT_W'(1);
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Key byte for the result slot presented next cycle
  assign w_sel = w_res_nxt[w_idx_nxt];
`ifdef KEYSTREAM_XOR_MIX_EN
  assign w_key_nxt = w_sel[7:0] ^ w_sel[15:8] ^ {1'b0, w_sel[22:16]};
`else
  logic w_unused_res;
  assign w_key_nxt    = w_sel[7:0];
  assign w_unused_res = ^w_sel[RES_W-1:8];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_trip      <= '0;
      r_in_ready  <= 1'b1;
      r_ext_en    <= 1'b0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_key_byte  <= '0;
      for (int i = 0; i < NUM_TRIP; i++) begin
        r_op[i]  <= '0;
        r_res[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_res       <= w_res_nxt;
      r_idx       <= w_idx_nxt;
      r_wait      <= w_wait_nxt;
      r_trip      <= w_trip_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_ext_en    <= (w_state_nxt == ST_RUN);
      r_key_valid <= (w_state_nxt == ST_EMIT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_key_byte  <= (w_state_nxt == ST_EMIT) ? w_key_nxt : key_byte_t'(0);
    end
  end

  assign in_ready  = r_in_ready;
  assign ext_en    = r_ext_en;
  assign ext_val   = r_op;
  assign key_valid = r_key_valid;
  assign key_byte  = r_key_byte;
  assign busy      = r_busy;
  assign trip_cnt  = r_trip;

endmodule

// File: tb/tb_keystream_scheduler.sv
// Directed self-checking bench for keystream_scheduler (default and CNT_W=2 instances).
module tb_keystream_scheduler;

  localparam int unsigned LAT  = 6;
  localparam int unsigned LAT2 = 1;

  typedef struct {
    logic [31:0] v [3];
    logic [22:0] r [3];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ext_en, key_valid, key_ready, busy;
  logic [31:0] in_val  [3];
  logic [31:0] ext_val [3];
  logic [22:0] ext_res [3];
  logic [7:0]  key_byte;
  logic [15:0] trip_cnt;

  logic        rst2, in_valid2, in_ready2, ext_en2, key_valid2, key_ready2, busy2;
  logic [31:0] in_val2  [3];
  logic [31:0] ext_val2 [3];
  logic [22:0] ext_res2 [3];
  logic [7:0]  key_byte2;
  logic [1:0]  trip_cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_trip = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  keystream_scheduler #(.EXTRACT_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .ext_en(ext_en), .ext_val(ext_val), .ext_res(ext_res), .key_valid(key_valid),
    .key_ready(key_ready), .key_byte(key_byte), .busy(busy), .trip_cnt(trip_cnt)
  );

  keystream_scheduler #(.EXTRACT_LAT(LAT2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_val(in_val2),
    .ext_en(ext_en2), .ext_val(ext_val2), .ext_res(ext_res2), .key_valid(key_valid2),
    .key_ready(key_ready2), .key_byte(key_byte2), .busy(busy2), .trip_cnt(trip_cnt2)
  );

  function automatic logic [7:0] mdl(input logic [22:0] r);
`ifdef KEYSTREAM_XOR_MIX_EN
    return r[7:0] ^ r[15:8] ^ {1'b0, r[22:16]};
`else
    return r[7:0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // One full triplet with key_ready held high; checks timing, operands and bytes
  task automatic run_trip(input vec_t t);
    int c, en_cnt, first_kv, first_rdy, nb;
    logic [7:0] got [3];
    c = 0;
    while (!in_ready && c < 50) begin @(negedge clk); c++; end
    ext_res = t.r; in_val = t.v; in_valid = 1'b1; key_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_val = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    en_cnt = 0; first_kv = 0; first_rdy = 0; nb = 0;
    got = '{8'h0, 8'h0, 8'h0};
    for (c = 1; c <= 40 && first_rdy == 0; c++) begin
      @(negedge clk);
      if (ext_en) en_cnt++;
      if (c == 1) begin
        for (int i = 0; i < 3; i++) chk("ext_val_run", 64'(ext_val[i]), 64'(t.v[i]));
        chk("in_ready_run", 64'(in_ready), 64'(0));
        chk("busy_run", 64'(busy), 64'(1));
      end
      if (key_valid) begin
        if (first_kv == 0) first_kv = c;
        if (nb < 3) got[nb] = key_byte;
        nb++;
      end
      if (in_ready) first_rdy = c;
    end
    exp_trip++;
    chk("ext_en_cycles", 64'(en_cnt), 64'(LAT));
    chk("first_key_valid", 64'(first_kv), 64'(LAT + 2));
    chk("in_ready_return", 64'(first_rdy), 64'(LAT + 5));
    chk("byte_count", 64'(nb), 64'(3));
    for (int i = 0; i < 3; i++) chk("key_byte", 64'(got[i]), 64'(mdl(t.r[i])));
    chk("trip_cnt", 64'(trip_cnt), 64'(exp_trip));
  endtask

  initial begin
    int c, kv_cnt, nseq, en2;
    logic [1:0] seq [4];
    logic [1:0] prev2;

    vecs[0].v = '{32'h3FC0_0000, 32'h4049_0FDB, 32'h3F80_0000};
    vecs[0].r = '{23'h000123, 23'h0004D2, 23'h00007B};
    vecs[1].v = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1].r = '{23'h7FFFFF, 23'h7FFF00, 23'h0000FF};
    vecs[2].v = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    vecs[2].r = '{23'h5A5A5A, 23'h2A5A00, 23'h400001};
    vecs[3].v = '{32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h0102_0304};
    vecs[3].r = '{23'h000080, 23'h7F00FF, 23'h010101};

    rst = 1'b1; in_valid = 1'b0; key_ready = 1'b1;
    in_val = '{32'h0, 32'h0, 32'h0}; ext_res = '{23'h0, 23'h0, 23'h0};
    rst2 = 1'b1; in_valid2 = 1'b0; key_ready2 = 1'b1;
    in_val2 = '{32'h0, 32'h0, 32'h0}; ext_res2 = '{23'h0, 23'h0, 23'h0};
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_ext_en", 64'(ext_en), 64'(0));
    chk("rst_key_valid", 64'(key_valid), 64'(0));
    chk("rst_key_byte", 64'(key_byte), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_trip_cnt", 64'(trip_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset in the third RUN cycle abandons the triplet
    ext_res = vecs[0].r; in_val = vecs[0].v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (c = 1; c <= 3; c++) @(negedge clk);
    chk("midrun_ext_en", 64'(ext_en), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_in_ready", 64'(in_ready), 64'(1));
    chk("rstrun_ext_en", 64'(ext_en), 64'(0));
    chk("rstrun_key_valid", 64'(key_valid), 64'(0));
    chk("rstrun_key_byte", 64'(key_byte), 64'(0));
    chk("rstrun_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) chk("rstrun_ext_val", 64'(ext_val[i]), 64'(0));
    kv_cnt = 0;
    for (c = 0; c < 15; c++) begin
      @(negedge clk);
      if (key_valid) kv_cnt++;
    end
    chk("rstrun_no_keys", 64'(kv_cnt), 64'(0));
    chk("rstrun_trip_cnt", 64'(trip_cnt), 64'(0));

    // Table-driven triplets
    for (int k = 0; k < 4; k++) run_trip(vecs[k]);

    // Consumer stall on the second byte; in_val changes must be ignored
    ext_res = vecs[0].r; in_val = vecs[0].v; in_valid = 1'b1; key_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!key_valid && c < 30);
    chk("stall_byte0", 64'(key_byte), 64'(mdl(vecs[0].r[0])));
    @(negedge clk);
    key_ready = 1'b0;
    chk("stall_byte1", 64'(key_byte), 64'(mdl(vecs[0].r[1])));
    for (int s = 0; s < 5; s++) begin
      in_valid = s[0];
      in_val = '{32'(s) ^ 32'h5555_0000, 32'hFFFF_0000, 32'(s)};
      @(negedge clk);
      chk("stall_hold_byte", 64'(key_byte), 64'(mdl(vecs[0].r[1])));
      chk("stall_hold_valid", 64'(key_valid), 64'(1));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    chk("stall_ext_val", 64'(ext_val[0]), 64'(vecs[0].v[0]));
    in_valid = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    chk("stall_byte2", 64'(key_byte), 64'(mdl(vecs[0].r[2])));
    @(negedge clk);
    exp_trip++;
    chk("stall_in_ready_back", 64'(in_ready), 64'(1));
    chk("stall_trip_cnt", 64'(trip_cnt), 64'(exp_trip));

    // Narrow counter wraps: four back-to-back triplets on the CNT_W=2 instance
    rst2 = 1'b0;
    ext_res2 = vecs[2].r; in_val2 = vecs[2].v; in_valid2 = 1'b1;
    nseq = 0; en2 = 0; prev2 = 2'd0;
    seq = '{2'd0, 2'd0, 2'd0, 2'd0};
    for (c = 0; c < 80 && nseq < 4; c++) begin
      @(negedge clk);
      if (ext_en2) en2++;
      if (trip_cnt2 != prev2 || (nseq == 3 && busy2 == 1'b0 && trip_cnt2 == 2'd0 && prev2 == 2'd3)) begin
        seq[nseq] = trip_cnt2;
        nseq++;
        prev2 = trip_cnt2;
      end
    end
    in_valid2 = 1'b0;
    chk("wrap_count", 64'(nseq), 64'(4));
    chk("wrap_seq0", 64'(seq[0]), 64'(1));
    chk("wrap_seq1", 64'(seq[1]), 64'(2));
    chk("wrap_seq2", 64'(seq[2]), 64'(3));
    chk("wrap_seq3", 64'(seq[3]), 64'(0));
    chk("wrap_ext_en_cycles", 64'(en2), 64'(4 * LAT2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
